// File: rtl/algorithm_update_scheduler_pkg.sv
// Shared types for the algorithm update scheduler: operator ID type, staged host write entry,
// and the scheduler FSM encoding.
package algorithm_update_scheduler_pkg;

   localparam int NUM_VOICE_OPERATORS = 192;
   localparam int OP_ID_W             = $clog2(NUM_VOICE_OPERATORS);

   typedef logic [OP_ID_W-1:0] VoiceOperatorID_t;

   localparam VoiceOperatorID_t OP_ID_LAST = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);

   typedef struct packed {
      VoiceOperatorID_t   addr;
      logic signed [15:0] data;
   } HostAlgWrite_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } sched_state_t;

   // True when the ID names a real operator slot (the ID type can encode more than exist).
   function automatic logic op_id_in_range(input VoiceOperatorID_t id);
      return id <= OP_ID_LAST;
   endfunction

endpackage

// File: rtl/algorithm_update_scheduler_sync_fifo.sv
// Synchronous FIFO with show-ahead head and registered full/empty/count.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Push,
   input  logic [WIDTH-1:0]      i_PushData,
   input  logic                  i_Pop,
   output logic [WIDTH-1:0]      o_Head,
   output logic                  o_Full,
   output logic                  o_Empty,
   output logic [$clog2(DEPTH):0] o_Count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   // Next pointers and occupancy; push when full and pop when empty are ignored.
   always_comb begin
      do_push  = i_Push && !full_q;
      do_pop   = i_Pop && !empty_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      full_d   = (count_d == (AW+1)'(DEPTH));
      empty_d  = (count_d == '0);
   end

   // Control state register.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset; occupancy decides what is meaningful.
   always_ff @(posedge i_Clock) begin
      if (do_push) mem_q[wr_ptr_q] <= i_PushData;
   end

   assign o_Head  = mem_q[rd_ptr_q];
   assign o_Full  = full_q;
   assign o_Empty = empty_q;
   assign o_Count = count_q;

endmodule

// File: rtl/algorithm_update_scheduler.sv
// Issues the per-cycle operator ID stream and applies staged host algorithm writes
// only between sample frames, stalling the ID stream for one cycle per applied entry.
module algorithm_update_scheduler
   import algorithm_update_scheduler_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   input  logic               i_HostWriteValid,
   output logic               o_HostWriteReady,
   input  VoiceOperatorID_t   i_HostWriteAddr,
   input  logic signed [15:0] i_HostWriteData,
   input  logic               i_Commit,
   output logic               o_CommitDone,
   output logic               o_AddrError,
   output VoiceOperatorID_t   o_VoiceOperator,
   output logic               o_VoiceOperatorValid,
   output logic               o_SampleStrobe,
   output logic               o_AlgorithmWriteEnable,
   output VoiceOperatorID_t   o_AlgorithmWriteAddr,
   output logic signed [15:0] o_AlgorithmWriteData
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = $bits(HostAlgWrite_t);

   sched_state_t       state_q, state_d;
   VoiceOperatorID_t   op_q, op_d;
   logic               op_valid_q, op_valid_d;
   logic               strobe_q, strobe_d;
   logic               commit_pend_q, commit_pend_d;
   logic               commit_done_q, commit_done_d;
   logic               addr_err_q, addr_err_d;
   logic               host_ready_q, host_ready_d;
   logic               wr_en_q, wr_en_d;
   VoiceOperatorID_t   wr_addr_q, wr_addr_d;
   logic signed [15:0] wr_data_q, wr_data_d;

   logic               host_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   fifo_cnt_nxt;
   logic [ENT_W-1:0]   fifo_head_raw;
   HostAlgWrite_t      fifo_head;
   HostAlgWrite_t      push_entry;

   assign host_push  = i_HostWriteValid && host_ready_q;
   assign push_entry = '{addr: i_HostWriteAddr, data: i_HostWriteData};
   assign fifo_head  = HostAlgWrite_t'(fifo_head_raw);

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .i_Push     (host_push),
      .i_PushData (push_entry),
      .i_Pop      (fifo_pop),
      .o_Head     (fifo_head_raw),
      .o_Full     (fifo_full),
      .o_Empty    (fifo_empty),
      .o_Count    (fifo_count)
   );

   // Next-state and next-output logic. Every output is computed one cycle ahead so it
   // leaves a flop; a pop happens on the edge that also loads the popped entry onto the
   // write port, so the entry appears on the port in the drain cycle it belongs to.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      op_valid_d    = op_valid_q;
      commit_pend_d = commit_pend_q | i_Commit;
      commit_done_d = 1'b0;
      fifo_pop      = 1'b0;
      wr_en_d       = 1'b0;
      wr_addr_d     = '0;
      wr_data_d     = '0;
      addr_err_d    = addr_err_q | (host_push && !op_id_in_range(i_HostWriteAddr));

      case (state_q)
         ST_RUN: begin
            op_valid_d = 1'b1;
            // Invalid output in RUN only happens right after reset: start the frame at 0.
            op_d = (!op_valid_q || op_q == OP_ID_LAST) ? '0 : op_q + VoiceOperatorID_t'(1);
            if (op_valid_q && op_q == OP_ID_LAST && commit_pend_d) begin
               commit_pend_d = 1'b0;
               if (!fifo_empty) begin
                  state_d    = ST_DRAIN;
                  op_valid_d = 1'b0;
                  op_d       = '0;
                  fifo_pop   = 1'b1;
               end else begin
                  commit_done_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            op_valid_d = 1'b0;
            op_d       = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
            end else begin
               state_d       = ST_RUN;
               op_valid_d    = 1'b1;
               commit_done_d = 1'b1;
            end
         end
      endcase

      // Out-of-range entries are consumed but never strobed into algorithm memory.
      if (fifo_pop) begin
         wr_en_d   = op_id_in_range(fifo_head.addr);
         wr_addr_d = fifo_head.addr;
         wr_data_d = fifo_head.data;
      end

      strobe_d     = op_valid_d && (op_d == '0);
      fifo_cnt_nxt = fifo_count + CNT_W'(host_push) - CNT_W'(fifo_pop);
      host_ready_d = (state_d == ST_RUN) && (fifo_cnt_nxt != CNT_W'(FIFO_DEPTH));
   end

   // State and output registers.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q       <= ST_RUN;
         op_q          <= '0;
         op_valid_q    <= 1'b0;
         strobe_q      <= 1'b0;
         commit_pend_q <= 1'b0;
         commit_done_q <= 1'b0;
         addr_err_q    <= 1'b0;
         host_ready_q  <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         op_valid_q    <= op_valid_d;
         strobe_q      <= strobe_d;
         commit_pend_q <= commit_pend_d;
         commit_done_q <= commit_done_d;
         addr_err_q    <= addr_err_d;
         host_ready_q  <= host_ready_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
      end
   end

   assign o_HostWriteReady       = host_ready_q;
   assign o_CommitDone           = commit_done_q;
   assign o_AddrError            = addr_err_q;
   assign o_VoiceOperator        = op_q;
   assign o_VoiceOperatorValid   = op_valid_q;
   assign o_SampleStrobe         = strobe_q;
   assign o_AlgorithmWriteEnable = wr_en_q;
   assign o_AlgorithmWriteAddr   = wr_addr_q;
   assign o_AlgorithmWriteData   = wr_data_q;

endmodule
